load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the CPU execute stage and data_memory.
- Turns MIPS load/store requests (LB, LBU, LH, LHU, LW, SB, SH, SW) into word-aligned accesses on the memory's data_* interface.
- data_memory only writes full 32-bit words, so SB/SH are done as read-modify-write.
- Holds busy high to stall the CPU until the access completes, then returns load data in a resp_valid pulse.

Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe; accepted only when busy=0
- req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, 10 SW; other codes are illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- busy  out  1  high whenever FSM is not IDLE
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- resp_rdata  out  32  extended load result; 0 for stores and illegal ops
- addr_error  out  1  valid with resp_valid (see Optional Feature)
- data_address  out  32  word-aligned address {addr[31:2],2'b00}
- data_read  out  1  memory read strobe
- data_write  out  1  memory write strobe; memory writes on posedge
- data_writedata  out  32  full word to write
- data_readdata  in  32  combinational read data, valid in the same cycle data_read=1

Behaviour:
- Byte lanes are little-endian: byte k of a word is bits [8k+7:8k], k=addr[1:0]. Halfword lane is addr[1] (bits [15:0] or [31:16]).
- Request capture: in IDLE with req_valid=1, register op/addr/wdata and go to ACCESS. req_valid while busy=1 is ignored, not queued.
- FSM states: IDLE, ACCESS, MERGE, RESP.
  - IDLE -> ACCESS on accept.
  - ACCESS, load: data_read=1; capture data_readdata at the edge; -> RESP.
  - ACCESS, SW: data_write=1, data_writedata=wdata; -> RESP.
  - ACCESS, SB/SH: data_read=1; capture the old word; -> MERGE.
  - MERGE: data_write=1; data_writedata = old word with the selected byte/halfword lane replaced by wdata[7:0]/wdata[15:0]; -> RESP.
  - RESP: resp_valid=1; -> IDLE.
  - Illegal op: ACCESS drives no strobe; -> RESP with resp_rdata=0.
- Latency, accept edge to resp_valid cycle: loads and SW 2 cycles; SB/SH 3 cycles.
- A new request can be accepted in the cycle after RESP.
- data_read and data_write are never high together. Each is high for exactly one cycle per access that needs it. Both are low in IDLE and RESP.
- data_address holds the aligned request address from ACCESS through RESP.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend. LW uses the whole word.
- resp_rdata is registered and holds its value until the next response.
- Reset (asynchronous, any state):
  - FSM -> IDLE.
  - busy, resp_valid, addr_error, data_read, data_write -> 0.
  - data_address, data_writedata, resp_rdata -> 0.
  - If reset lands in MERGE before the write edge, no write is issued. No response is produced for the aborted request.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is misaligned.
  - Misaligned requests skip memory: ACCESS asserts no strobe, then RESP pulses with addr_error=1 and resp_rdata=0. Same latency as a load.
  - addr_error=0 on all other responses.
- Not defined:
  - addr_error is tied to 0.
  - Halfword ops ignore addr[0]; LW/SW ignore addr[1:0].

Test Plan:
- Memory word 0x100 = 0x8899AABB; LB 0x103 -> resp_rdata 0xFFFFFF88 two cycles after accept; one data_read pulse at address 0x100.
- Same word; LBU 0x102 -> 0x00000099; LH 0x100 -> 0xFFFFAABB; LHU 0x102 -> 0x00008899.
- SH 0x102, wdata 0x00001234 -> read at 0x100, then a single data_write of 0x1234AABB in MERGE; resp_valid on the 3rd cycle; a following LW 0x100 returns 0x1234AABB.
- SB 0x101, wdata 0xCC; assert reset_n=0 during MERGE -> no data_write, all outputs 0; memory still holds 0x8899AABB.
- Issue SW 0x200 0xDEADBEEF, then hold req_valid with LW 0x100 while busy -> the second request is ignored until IDLE; SW writes 0xDEADBEEF at 0x200 once.
- With LSU_ALIGN_CHECK_EN: LW 0x101 -> no data_read; resp_valid with addr_error=1 and resp_rdata=0. Without the macro: the same request returns the word at 0x100.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Turns MIPS byte/halfword/word load and store requests from the execute stage
//   into word-aligned accesses on the data memory interface. The memory only
//   writes full 32-bit words, so SB/SH are done as a read-modify-write. busy
//   stalls the CPU while an access is in flight. resp_valid pulses for one cycle
//   when the access completes.
//
// Optional feature (compile-time macro LSU_ALIGN_CHECK_EN):
//   defined     - misaligned LH/LHU/SH/LW/SW skip memory and respond with
//                 addr_error=1 and resp_rdata=0
//   not defined - addr_error is tied low; halfword ops ignore addr[0] and
//                 word ops ignore addr[1:0]
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   req_valid         request strobe, accepted only when busy=0
//   req_op[3:0]       0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, 10 SW
//   req_addr[31:0]    byte address
//   req_wdata[31:0]   right-aligned store data
//   busy              high whenever the FSM is not idle
//   resp_valid        one-cycle completion pulse
//   resp_rdata[31:0]  registered, extended load result (0 for stores/illegal)
//   addr_error        misalignment flag, valid with resp_valid
//   data_address      word-aligned memory address
//   data_read         memory read strobe
//   data_write        memory write strobe
//   data_writedata    full word to write
//   data_readdata     combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_error,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpSb  = 4'd8;
    localparam logic [3:0] OpSh  = 4'd9;
    localparam logic [3:0] OpSw  = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StMerge,
        StResp
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_old;
    logic [31:0] r_rdata;

    logic        w_is_load;
    logic        w_is_rmw;
    logic        w_is_sw;
    logic        w_misaligned;
    logic        w_do_read;
    logic        w_do_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;
    logic [31:0] w_resp_data;
    logic        w_read;
    logic        w_write;
    logic [31:0] w_writedata;

    // ---------------------------------------------------------------------
    // Decode of the captured request
    // ---------------------------------------------------------------------
    always_comb begin
        w_is_load = (r_op == OpLb) || (r_op == OpLbu) || (r_op == OpLh) ||
                    (r_op == OpLhu) || (r_op == OpLw);
        w_is_rmw  = (r_op == OpSb) || (r_op == OpSh);
        w_is_sw   = (r_op == OpSw);
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = (((r_op == OpLh) || (r_op == OpLhu) || (r_op == OpSh)) && r_addr[0]) ||
                       (((r_op == OpLw) || (r_op == OpSw)) && (r_addr[1:0] != 2'b00));
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // Illegal and misaligned ops fall through both terms and touch no strobe.
    assign w_do_read = (w_is_load || w_is_rmw) && !w_misaligned;
    assign w_do_sw   = w_is_sw && !w_misaligned;

    // ---------------------------------------------------------------------
    // Load lane select and extension
    // ---------------------------------------------------------------------
    always_comb begin
        w_byte = data_readdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? data_readdata[31:16] : data_readdata[15:0];
        case (r_op)
            OpLb:    w_load_ext = {{24{w_byte[7]}}, w_byte};
            OpLbu:   w_load_ext = {24'h000000, w_byte};
            OpLh:    w_load_ext = {{16{w_half[15]}}, w_half};
            OpLhu:   w_load_ext = {16'h0000, w_half};
            OpLw:    w_load_ext = data_readdata;
            default: w_load_ext = 32'h0000_0000;
        endcase
    end

    // ---------------------------------------------------------------------
    // Store merge: old word with the addressed lane replaced
    // ---------------------------------------------------------------------
    always_comb begin
        w_merged = r_old;
        if (r_op == OpSb) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and memory strobes
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_writedata  = 32'h0000_0000;
        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                if (w_do_read) begin
                    w_read       = 1'b1;
                    w_state_next = w_is_rmw ? StMerge : StResp;
                end else if (w_do_sw) begin
                    w_write      = 1'b1;
                    w_writedata  = r_wdata;
                    w_state_next = StResp;
                end else begin
                    w_state_next = StResp;
                end
            end
            StMerge: begin
                w_write      = 1'b1;
                w_writedata  = w_merged;
                w_state_next = StResp;
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Only a real load completing from ACCESS carries data; everything else
    // (stores, illegal, misaligned) responds with zero.
    assign w_resp_data = ((r_state == StAccess) && w_do_read && w_is_load) ? w_load_ext
                                                                           : 32'h0000_0000;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_op    <= 4'h0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_old   <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && req_valid) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if ((r_state == StAccess) && w_do_read && w_is_rmw) begin
                r_old <= data_readdata;
            end
            // Update only on entry to RESP so the result holds until the next one.
            if ((r_state != StResp) && (w_state_next == StResp)) begin
                r_rdata <= w_resp_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy           = (r_state != StIdle);
    assign resp_valid     = (r_state == StResp);
    assign resp_rdata     = r_rdata;
    assign addr_error     = (r_state == StResp) && w_misaligned;
    assign data_address   = {r_addr[31:2], 2'b00};
    assign data_read      = w_read;
    assign data_write     = w_write;
    assign data_writedata = w_writedata;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit. A small word memory model answers
//   data_read combinationally and writes on posedge. Expected responses (data,
//   addr_error, due cycle) are queued when a request is driven and compared
//   when resp_valid appears. Honours LSU_ALIGN_CHECK_EN for the alignment cases.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpSb  = 4'd8;
    localparam logic [3:0] OpSh  = 4'd9;
    localparam logic [3:0] OpSw  = 4'd10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .addr_error     (addr_error),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    assign data_readdata = mem[data_address[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (data_write) mem[data_address[9:2]] <= data_writedata;
    end

    // Strobe accounting and response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (data_read) begin
            rd_cnt = rd_cnt + 1;
            last_rd_addr = data_address;
        end
        if (data_write) begin
            wr_cnt = wr_cnt + 1;
            last_wr_addr = data_address;
            last_wr_data = data_writedata;
        end
        if (data_read && data_write) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL strobe_overlap: got read=1 write=1, required at most one");
        end
        if (resp_valid) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_resp: got resp_rdata=%h at cycle %0d, required none",
                         resp_rdata, cyc);
            end else begin
                e = sb_q.pop_front();
                if (resp_rdata !== e.rdata) begin
                    errors = errors + 1;
                    $display("FAIL resp_rdata: got %h, required %h", resp_rdata, e.rdata);
                end
                checks = checks + 1;
                if (addr_error !== e.err) begin
                    errors = errors + 1;
                    $display("FAIL addr_error: got %b, required %b", addr_error, e.err);
                end
                checks = checks + 1;
                if (cyc != e.due) begin
                    errors = errors + 1;
                    $display("FAIL resp_latency: got cycle %0d, required cycle %0d", cyc, e.due);
                end
            end
        end
    end

    // Called just after a posedge; drives the request and queues its response.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        e.rdata   = rdata;
        e.err     = err;
        e.due     = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout: got %0d pending responses, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic req_single(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata,
                              input logic err, input int lat);
        issue(op, addr, wd, rdata, err, lat);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #12;
        checks = checks + 8;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_resp_valid: got %b, required 0", resp_valid);
        end
        if (addr_error !== 1'b0) begin
            errors++; $display("FAIL rst_addr_error: got %b, required 0", addr_error);
        end
        if (data_read !== 1'b0) begin
            errors++; $display("FAIL rst_data_read: got %b, required 0", data_read);
        end
        if (data_write !== 1'b0) begin
            errors++; $display("FAIL rst_data_write: got %b, required 0", data_write);
        end
        if (data_address !== 32'h0) begin
            errors++; $display("FAIL rst_data_address: got %h, required 0", data_address);
        end
        if (data_writedata !== 32'h0) begin
            errors++; $display("FAIL rst_writedata: got %h, required 0", data_writedata);
        end
        if (resp_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_resp_rdata: got %h, required 0", resp_rdata);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        int r0;
        int w0;
        w0 = wr_cnt;
        req_single(OpSw, 32'h100, 32'h8899AABB, 32'h0, 1'b0, 2);
        checks = checks + 2;
        if (wr_cnt != w0 + 1) begin
            errors++; $display("FAIL sw_write_count: got %0d, required %0d", wr_cnt - w0, 1);
        end
        if (last_wr_data !== 32'h8899AABB) begin
            errors++; $display("FAIL sw_write_data: got %h, required 8899aabb", last_wr_data);
        end
        r0 = rd_cnt;
        req_single(OpLb, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        checks = checks + 2;
        if (rd_cnt != r0 + 1) begin
            errors++; $display("FAIL lb_read_count: got %0d, required 1", rd_cnt - r0);
        end
        if (last_rd_addr !== 32'h100) begin
            errors++; $display("FAIL lb_read_addr: got %h, required 00000100", last_rd_addr);
        end
        req_single(OpLbu, 32'h102, 32'h0, 32'h00000099, 1'b0, 2);
        req_single(OpLh,  32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 2);
        req_single(OpLhu, 32'h102, 32'h0, 32'h00008899, 1'b0, 2);
        req_single(OpLb,  32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 2);
        req_single(OpLbu, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2);
        req_single(OpLw,  32'h100, 32'h0, 32'h8899AABB, 1'b0, 2);
    endtask

    task automatic test_store_merge();
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        req_single(OpSh, 32'h102, 32'h00001234, 32'h0, 1'b0, 3);
        checks = checks + 4;
        if (rd_cnt != r0 + 1) begin
            errors++; $display("FAIL sh_read_count: got %0d, required 1", rd_cnt - r0);
        end
        if (wr_cnt != w0 + 1) begin
            errors++; $display("FAIL sh_write_count: got %0d, required 1", wr_cnt - w0);
        end
        if (last_wr_data !== 32'h1234AABB) begin
            errors++; $display("FAIL sh_write_data: got %h, required 1234aabb", last_wr_data);
        end
        if (last_wr_addr !== 32'h100) begin
            errors++; $display("FAIL sh_write_addr: got %h, required 00000100", last_wr_addr);
        end
        req_single(OpLw, 32'h100, 32'h0, 32'h1234AABB, 1'b0, 2);
        req_single(OpSb, 32'h100, 32'hFFFFFF77, 32'h0, 1'b0, 3);
        req_single(OpSb, 32'h103, 32'h000000EE, 32'h0, 1'b0, 3);
        req_single(OpLw, 32'h100, 32'h0, 32'hEE34AA77, 1'b0, 2);
        req_single(OpSh, 32'h100, 32'h0000BEEF, 32'h0, 1'b0, 3);
        req_single(OpLw, 32'h100, 32'h0, 32'hEE34BEEF, 1'b0, 2);
        req_single(OpSw, 32'h100, 32'h8899AABB, 32'h0, 1'b0, 2);
        req_single(OpLw, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2);
    endtask

    task automatic test_reset_merge();
        int w0;
        w0 = wr_cnt;
        // Not queued: the aborted request must produce no response.
        req_valid = 1'b1;
        req_op    = OpSb;
        req_addr  = 32'h101;
        req_wdata = 32'h000000CC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks = checks + 6;
        if (data_write !== 1'b0) begin
            errors++; $display("FAIL rstm_data_write: got %b, required 0", data_write);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstm_busy: got %b, required 0", busy); end
        if (data_address !== 32'h0) begin
            errors++; $display("FAIL rstm_data_address: got %h, required 0", data_address);
        end
        if (data_writedata !== 32'h0) begin
            errors++; $display("FAIL rstm_writedata: got %h, required 0", data_writedata);
        end
        if (resp_rdata !== 32'h0) begin
            errors++; $display("FAIL rstm_resp_rdata: got %h, required 0", resp_rdata);
        end
        if (data_read !== 1'b0) begin
            errors++; $display("FAIL rstm_data_read: got %b, required 0", data_read);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks = checks + 1;
        if (wr_cnt != w0) begin
            errors++; $display("FAIL rstm_write_count: got %0d, required 0", wr_cnt - w0);
        end
        req_single(OpLw, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        int   w0;
        exp_t e;
        w0 = wr_cnt;
        issue(OpSw, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        @(posedge clk);
        #1;
        // Held while busy: must be taken only once the FSM is back in IDLE.
        req_op    = OpLw;
        req_addr  = 32'h100;
        req_wdata = 32'h0;
        e.rdata   = 32'h8899AABB;
        e.err     = 1'b0;
        e.due     = cyc + 4;
        sb_q.push_back(e);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_done();
        checks = checks + 3;
        if (wr_cnt != w0 + 1) begin
            errors++; $display("FAIL b2b_write_count: got %0d, required 1", wr_cnt - w0);
        end
        if (last_wr_addr !== 32'h200) begin
            errors++; $display("FAIL b2b_write_addr: got %h, required 00000200", last_wr_addr);
        end
        if (last_wr_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL b2b_write_data: got %h, required deadbeef", last_wr_data);
        end
        req_single(OpLw, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    endtask

    task automatic test_illegal_align();
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        req_single(4'd5,  32'h100, 32'h12345678, 32'h0, 1'b0, 2);
        req_single(4'd15, 32'h200, 32'h12345678, 32'h0, 1'b0, 2);
        checks = checks + 2;
        if (rd_cnt != r0) begin
            errors++; $display("FAIL illegal_read_count: got %0d, required 0", rd_cnt - r0);
        end
        if (wr_cnt != w0) begin
            errors++; $display("FAIL illegal_write_count: got %0d, required 0", wr_cnt - w0);
        end
        r0 = rd_cnt;
`ifdef LSU_ALIGN_CHECK_EN
        req_single(OpLw, 32'h101, 32'h0, 32'h0, 1'b1, 2);
        checks = checks + 1;
        if (rd_cnt != r0) begin
            errors++; $display("FAIL align_lw_read: got %0d reads, required 0", rd_cnt - r0);
        end
        req_single(OpLh, 32'h103, 32'h0, 32'h0, 1'b1, 2);
        req_single(OpSw, 32'h202, 32'h11111111, 32'h0, 1'b1, 2);
        req_single(OpSh, 32'h201, 32'h00002222, 32'h0, 1'b1, 2);
        req_single(OpLw, 32'h200, 32'h0, 32'hDEADBEEF, 1'b0, 2);
`else
        req_single(OpLw, 32'h101, 32'h0, 32'h8899AABB, 1'b0, 2);
        checks = checks + 1;
        if (rd_cnt != r0 + 1) begin
            errors++; $display("FAIL align_lw_read: got %0d reads, required 1", rd_cnt - r0);
        end
        req_single(OpLh, 32'h103, 32'h0, 32'hFFFF8899, 1'b0, 2);
        req_single(OpSw, 32'h202, 32'h11111111, 32'h0, 1'b0, 2);
        req_single(OpSh, 32'h201, 32'h00002222, 32'h0, 1'b0, 3);
        req_single(OpLw, 32'h200, 32'h0, 32'h11112222, 1'b0, 2);
`endif
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_merge();
        test_reset_merge();
        test_back_to_back();
        test_illegal_align();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
